data_stream_tx: RTL and testbench

DATA_STREAM_TX -- requirements
Module: data_stream_tx

---
 rtl/data_stream_tx_pkg.sv | 15 +
 rtl/axi_if.sv | 14 +
 rtl/tx_fifo.sv | 46 ++++
 rtl/data_stream_tx.sv | 97 +++++++++
 tb/tb_data_stream_tx.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_stream_tx_pkg.sv
// Shared stream framing constants and tx state encoding, reused by stream receivers.
// Pure definitions: no latency, no backpressure.
package data_stream_tx_pkg;

  localparam int FRAME_SIZE = 4;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;
  localparam int BEAT_W     = $clog2(FRAME_SIZE);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/axi_if.sv
// Byte-wide stream link: master drives tvalid/tdata/tid/tlast, slave drives tready.
// Wires only: no latency; tready is the sole backpressure signal.
interface axi_if;

  logic                                  tvalid;
  logic [data_stream_tx_pkg::BYTE_W-1:0] tdata;
  logic [data_stream_tx_pkg::BYTE_W-1:0] tid;
  logic                                  tlast;
  logic                                  tready;

  modport master (output tvalid, tdata, tid, tlast, input tready);
  modport slave  (input tvalid, tdata, tid, tlast, output tready);

endinterface

// File: rtl/tx_fifo.sv
// Generic power-of-two FIFO; one-cycle write-to-read latency, head word shown combinationally.
// Backpressure: pushes are dropped while full and pops ignored while empty; callers gate on the flags.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/data_stream_tx.sv
// Buffers 32-bit words and serialises each as a 4-beat MSB-first stream frame; tvalid one cycle after a word lands in an idle, empty FIFO.
// Backpressure: tready stalls the serialiser with beats held stable; tx_ready drops when the FIFO is full.
module data_stream_tx
  import data_stream_tx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] DEST_ID    = 8'h7A,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  axi_if.master             axi
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_SIZE - 1);

  tx_state_e         state;
  logic [WORD_W-1:0] shift_q;
  logic [BEAT_W-1:0] beat_cnt;
  logic              tvalid_q;
  logic              beat_done;
  logic              last_beat;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_head;

  assign beat_done = tvalid_q && axi.tready;
  assign last_beat = (beat_cnt == LAST_BEAT);
  // Refill at the last beat keeps frames back-to-back with no tvalid bubble.
  assign fifo_pop  = !fifo_empty && ((state == IDLE) || (beat_done && last_beat));

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_q   <= '0;
      beat_cnt  <= '0;
      tvalid_q  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            shift_q  <= fifo_head;
            beat_cnt <= '0;
            tvalid_q <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (beat_done) begin
            if (!last_beat) begin
              shift_q  <= {shift_q[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end else begin
              frame_cnt <= frame_cnt + 16'd1;
              beat_cnt  <= '0;
              if (fifo_pop) begin
                shift_q <= fifo_head;
              end else begin
                tvalid_q <= 1'b0;
                state    <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx_ready   = !fifo_full;
  assign busy       = (state != IDLE) || !fifo_empty;
  assign axi.tvalid = tvalid_q;
  assign axi.tdata  = shift_q[WORD_W-1 -: BYTE_W];
  assign axi.tid    = DEST_ID;
  assign axi.tlast  = tvalid_q && last_beat;

endmodule

// File: tb/tb_data_stream_tx.sv
// Bench for data_stream_tx: per-scenario tasks plus a beat scoreboard fed on word acceptance.
module tb_data_stream_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        tready = 1'b0;

  int checks = 0;
  int errors = 0;
  int beats_seen = 0;

  logic [8:0] exp_q[$];
  logic [8:0] exp_beat;
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic       prev_l = 1'b0;
  logic [7:0] prev_d = '0;

  axi_if axi();
  assign axi.tready = tready;

  data_stream_tx #(
    .DEST_ID    (8'h7A),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .axi       (axi)
  );

  always #5 clk = ~clk;

  // Beat monitor: stalled beats must hold, completed beats must match the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        checks++;
        if (axi.tvalid !== 1'b1 || axi.tdata !== prev_d || axi.tlast !== prev_l || axi.tid !== 8'h7A) begin
          errors++;
          $display("FAIL stability: tvalid=%b tdata=%h tlast=%b tid=%h, required tvalid=1 tdata=%h tlast=%b tid=7a",
                   axi.tvalid, axi.tdata, axi.tlast, axi.tid, prev_d, prev_l);
        end
      end
      if (axi.tvalid === 1'b1 && axi.tready === 1'b1) begin
        beats_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat: unexpected beat tdata=%h tlast=%b, required no beat", axi.tdata, axi.tlast);
        end else begin
          exp_beat = exp_q.pop_front();
          if ({axi.tdata, axi.tlast} !== exp_beat || axi.tid !== 8'h7A) begin
            errors++;
            $display("FAIL beat: tdata=%h tlast=%b tid=%h, required tdata=%h tlast=%b tid=7a",
                     axi.tdata, axi.tlast, axi.tid, exp_beat[8:1], exp_beat[0]);
          end
        end
      end
      prev_v = axi.tvalid;
      prev_r = axi.tready;
      prev_d = axi.tdata;
      prev_l = axi.tlast;
    end
  end

  task automatic expect_word(input logic [31:0] w);
    exp_q.push_back({w[31:24], 1'b0});
    exp_q.push_back({w[23:16], 1'b0});
    exp_q.push_back({w[15:8],  1'b0});
    exp_q.push_back({w[7:0],   1'b1});
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push_word(input logic [31:0] w);
    bit accepted = 1'b0;
    tx_data  = w;
    tx_valid = 1'b1;
    for (int i = 0; i < 300 && !accepted; i++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) begin
        expect_word(w);
        accepted = 1'b1;
      end
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL push_timeout: word %h accepted=0, required 1", w);
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b pending_beats=%0d, required busy=0 pending=0", busy, exp_q.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (axi.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: %b, required 0", axi.tvalid); end
    checks++; if (axi.tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: %b, required 0", axi.tlast); end
    checks++; if (axi.tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata: %h, required 00", axi.tdata); end
    checks++; if (axi.tid !== 8'h7A) begin errors++; $display("FAIL rst_tid: %h, required 7a", axi.tid); end
    checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL rst_frame_cnt: %h, required 0000", frame_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b, required 0", busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL post_rst_tx_ready: %b, required 1", tx_ready); end
  endtask

  task automatic test_basic;
    tready = 1'b1;
    push_word(32'hDEADBEEF);
    checks++; if (axi.tvalid !== 1'b0) begin errors++; $display("FAIL latency_early: tvalid=%b, required 0", axi.tvalid); end
    @(posedge clk); #1;
    checks++;
    if (axi.tvalid !== 1'b1 || axi.tdata !== 8'hDE) begin
      errors++;
      $display("FAIL latency: tvalid=%b tdata=%h, required tvalid=1 tdata=de", axi.tvalid, axi.tdata);
    end
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (axi.tvalid !== 1'b0 || frame_cnt !== 16'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_frame: tvalid=%b frame_cnt=%0d pending=%0d, required 0 1 0", axi.tvalid, frame_cnt, exp_q.size());
    end
  endtask

  task automatic test_stall;
    tready = 1'b0;
    push_word(32'h12345678);
    @(posedge clk); #1;
    checks++; if (axi.tdata !== 8'h12) begin errors++; $display("FAIL stall_beat0: %h, required 12", axi.tdata); end
    tready = 1'b1;
    @(posedge clk); #1;
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (axi.tvalid !== 1'b1 || axi.tdata !== 8'h34) begin
        errors++;
        $display("FAIL stall_hold: tvalid=%b tdata=%h, required tvalid=1 tdata=34", axi.tvalid, axi.tdata);
      end
    end
    tready = 1'b1;
    wait_idle(20);
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL stall_frame_cnt: %0d, required 2", frame_cnt); end
  endtask

  // One word moves straight into the serialiser, so FIFO_DEPTH+1 words fit before tx_ready drops.
  task automatic test_back_to_back;
    int acc = 0;
    int cycles = 0;
    int base_b;
    logic [15:0] base_f;
    base_f = frame_cnt;
    tready = 1'b0;
    tx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tx_data = 32'hB0C0_0000 + 32'(acc);
      @(negedge clk);
      if (tx_ready !== 1'b1) break;
      expect_word(tx_data);
      acc++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checks++; if (acc != 5) begin errors++; $display("FAIL b2b_accepted: %0d, required 5", acc); end
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (tx_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_full: tx_ready=%b busy=%b, required 0 1", tx_ready, busy);
    end
    base_b = beats_seen;
    fork
      push_word(32'hB0C0_0005);
      begin
        tready = 1'b1;
        while (beats_seen - base_b < 24 && cycles < 100) begin
          @(posedge clk); #1;
          cycles++;
        end
      end
    join
    checks++; if (cycles != 24) begin errors++; $display("FAIL b2b_contiguous: %0d cycles for 24 beats, required 24", cycles); end
    wait_idle(50);
    checks++; if (frame_cnt !== base_f + 16'd6) begin errors++; $display("FAIL b2b_frame_cnt: %0d, required %0d", frame_cnt, base_f + 16'd6); end
  endtask

  task automatic test_reset_mid;
    tready = 1'b0;
    push_word(32'h11223344);
    @(posedge clk); #1;
    tready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    tready = 1'b0;
    checks++; if (axi.tdata !== 8'h33) begin errors++; $display("FAIL mid_beat2: %h, required 33", axi.tdata); end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (axi.tvalid !== 1'b0 || axi.tlast !== 1'b0 || frame_cnt !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: tvalid=%b tlast=%b frame_cnt=%0d busy=%b, required 0 0 0 0", axi.tvalid, axi.tlast, frame_cnt, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (axi.tvalid !== 1'b0) begin errors++; $display("FAIL mid_no_restart: tvalid=%b, required 0", axi.tvalid); end
    tready = 1'b1;
    push_word(32'hA5A5A5A5);
    @(posedge clk); #1;
    checks++; if (axi.tvalid !== 1'b1 || axi.tdata !== 8'hA5 || axi.tlast !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart: tvalid=%b tdata=%h tlast=%b, required 1 a5 0", axi.tvalid, axi.tdata, axi.tlast);
    end
    wait_idle(20);
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL mid_frame_cnt: %0d, required 1", frame_cnt); end
  endtask

  task automatic test_wrap;
    force dut.frame_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_cnt;
    #1;
    checks++; if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: %h, required ffff", frame_cnt); end
    tready = 1'b1;
    push_word(32'h0F1E2D3C);
    wait_idle(20);
    checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap: %h, required 0000", frame_cnt); end
  endtask

  task automatic test_random;
    bit prod_done = 1'b0;
    logic [15:0] base_f;
    base_f = frame_cnt;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          push_word($urandom);
        end
        prod_done = 1'b1;
      end
      begin
        while (!prod_done) begin
          tready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        tready = 1'b1;
      end
    join
    wait_idle(200);
    checks++; if (frame_cnt !== base_f + 16'd1000) begin errors++; $display("FAIL random_frames: %0d, required %0d", frame_cnt, base_f + 16'd1000); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
